// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encoding,
// opcode/funct constants, ALU control codes, the ALU operation class
// handed to the ALU decoder, and the alu_src_b / pc_src encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle controller.
// master: the controller (consumes opcode/funct/zero/mem_ready, drives all
//         selects, enables and status pulses).
// slave:  the datapath/memory side.
interface multicycle_control_if #(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 4
);
  logic [OP_W-1:0]     opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_ne;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                reg_write;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUCTL_W-1:0] alu_ctl;
  logic [1:0]          pc_src;
  logic                instr_done;
  logic                illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_ctl, pc_src, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_ctl, pc_src, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decoder (combinational).
// alu_op      : operation class (add / sub / decode from funct)
// funct       : R-type funct field
// alu_ctl     : ALU control code
// funct_valid : funct is one of the supported R-type operations
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 4
) (
  input  alu_op_t             alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                funct_valid
);
  logic [ALUCTL_W-1:0] funct_ctl;

  always_comb begin
    funct_valid = 1'b1;
    funct_ctl   = ALUCTL_W'(ALU_ADD);
    case (funct)
      FUNCT_W'(FN_ADD): funct_ctl = ALUCTL_W'(ALU_ADD);
      FUNCT_W'(FN_SUB): funct_ctl = ALUCTL_W'(ALU_SUB);
      FUNCT_W'(FN_AND): funct_ctl = ALUCTL_W'(ALU_AND);
      FUNCT_W'(FN_OR):  funct_ctl = ALUCTL_W'(ALU_OR);
      FUNCT_W'(FN_SLT): funct_ctl = ALUCTL_W'(ALU_SLT);
      default:          funct_valid = 1'b0;
    endcase

    alu_ctl = ALUCTL_W'(ALU_ADD);
    case (alu_op)
      ALUOP_SUB:   alu_ctl = ALUCTL_W'(ALU_SUB);
      ALUOP_FUNCT: alu_ctl = funct_ctl;
      default:     alu_ctl = ALUCTL_W'(ALU_ADD);
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle datapath control FSM.
// clk, reset : clock and synchronous active-high reset
// bus        : master side of multicycle_control_if (opcode/funct/zero/
//              mem_ready in; PC, memory, IR, register-file and ALU selects
//              and enables out, plus instr_done / illegal pulses)
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  state_t              state, state_next;
  logic                is_load;
  alu_op_t             alu_op;
  logic                use_alu;
  logic [ALUCTL_W-1:0] dec_ctl;
  logic                funct_valid;
  logic                bad_instr;

  alu_decoder #(.FUNCT_W(FUNCT_W), .ALUCTL_W(ALUCTL_W)) u_alu_dec (
    .alu_op      (alu_op),
    .funct       (bus.funct),
    .alu_ctl     (dec_ctl),
    .funct_valid (funct_valid)
  );

  // LW/SW is resolved in DECODE and remembered, so MEM_ADDR does not
  // depend on opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      is_load <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) is_load <= (bus.opcode == OP_W'(OP_LW));
    end
  end

  // ALU class depends on state only; kept apart from the output block so
  // the decoder result does not loop back through the same process.
  always_comb begin
    alu_op  = ALUOP_ADD;
    use_alu = 1'b0;
    case (state)
      S_FETCH, S_DECODE, S_MEM_ADDR, S_I_EXEC: use_alu = 1'b1;
      S_R_EXEC: begin alu_op = ALUOP_FUNCT; use_alu = 1'b1; end
      S_BRANCH: begin alu_op = ALUOP_SUB;   use_alu = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_next        = state;
    bad_instr         = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.pc_src        = PCSRC_ALU;
    bus.instr_done    = 1'b0;
    bus.illegal       = 1'b0;
    bus.alu_ctl       = (use_alu && !reset) ? dec_ctl : '0;

    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = SRCB_IMM_SH2;
          case (bus.opcode)
            OP_W'(OP_LW), OP_W'(OP_SW): state_next = S_MEM_ADDR;
            OP_W'(OP_RTYPE): begin
              if (funct_valid) state_next = S_R_EXEC;
              else             bad_instr  = 1'b1;
            end
            OP_W'(OP_ADDI):             state_next = S_I_EXEC;
            OP_W'(OP_BEQ), OP_W'(OP_BNE): state_next = S_BRANCH;
            OP_W'(OP_J):                state_next = S_JUMP;
            default:                    bad_instr  = 1'b1;
          endcase
          if (bad_instr) begin
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = S_FETCH;
          end
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          state_next    = is_load ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ready) state_next = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          state_next     = S_FETCH;
        end
        S_MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_next     = S_FETCH;
          end
        end
        S_R_EXEC: begin
          bus.alu_src_a = 1'b1;
          state_next    = S_R_WB;
        end
        S_R_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
          state_next     = S_FETCH;
        end
        S_I_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          state_next    = S_I_WB;
        end
        S_I_WB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          state_next     = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.pc_write_cond = 1'b1;
          bus.pc_src        = PCSRC_ALUOUT;
          bus.branch_ne     = (bus.opcode == OP_W'(OP_BNE));
          bus.instr_done    = 1'b1;
          state_next        = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_src     = PCSRC_JUMP;
          bus.instr_done = 1'b1;
          state_next     = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.OP_W(6), .FUNCT_W(6), .ALUCTL_W(4)) bus ();

  multicycle_control #(.OP_W(6), .FUNCT_W(6), .ALUCTL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cycles, rd, wr, rw, rw_rd, m2r, irw, pcw, pcc, bne, ill, both, ctl;
  } stats_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int unsigned cyc, rw, pcc, bne, ill, ctl;
  } vec_t;

  logic [20:0] trace [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_ctl, bus.pc_src, bus.instr_done, bus.illegal};
  endfunction

  function automatic logic [20:0] w(input logic pcw, pcc, bne, iod, mr, mw,
                                    irw, rdst, rw, m2r, sa,
                                    input logic [1:0] sb, input logic [3:0] ac,
                                    input logic [1:0] ps, input logic done, ill);
    return {pcw, pcc, bne, iod, mr, mw, irw, rdst, rw, m2r, sa, sb, ac, ps, done, ill};
  endfunction

  // Reference: per-instruction totals from the instruction class and the
  // memory latencies (l0 = fetch wait cycles, l1 = data-access wait cycles).
  function automatic stats_t model(input logic [5:0] op, fn,
                                   input int unsigned l0, l1);
    stats_t s;
    bit r_ok, legal, is_mem, is_br;
    s = '{default: 0};
    r_ok   = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    legal  = r_ok || (op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02});
    is_mem = (op == 6'h23) || (op == 6'h2B);
    is_br  = (op == 6'h04) || (op == 6'h05);
    if (!legal)                         s.cycles = 2;
    else if (op == 6'h23)               s.cycles = 5;
    else if (is_br || op == 6'h02)      s.cycles = 3;
    else                                s.cycles = 4;
    s.cycles += l0 + (is_mem ? l1 : 0);
    s.rd    = 1 + l0 + ((op == 6'h23) ? 1 + l1 : 0);
    s.wr    = (op == 6'h2B) ? 1 + l1 : 0;
    s.rw    = (r_ok || op == 6'h08 || op == 6'h23) ? 1 : 0;
    s.rw_rd = r_ok ? 1 : 0;
    s.m2r   = (op == 6'h23) ? 1 : 0;
    s.irw   = 1;
    s.pcw   = (op == 6'h02) ? 2 : 1;
    s.pcc   = is_br ? 1 : 0;
    s.bne   = (op == 6'h05) ? 1 : 0;
    s.ill   = legal ? 0 : 1;
    s.both  = 0;
    if (r_ok) begin
      case (fn)
        6'h20:   s.ctl = 2;
        6'h22:   s.ctl = 6;
        6'h24:   s.ctl = 0;
        6'h25:   s.ctl = 1;
        default: s.ctl = 7;
      endcase
    end else if (is_br)                       s.ctl = 6;
    else if (op == 6'h08 || is_mem)           s.ctl = 2;
    else                                      s.ctl = 15;
    return s;
  endfunction

  // Runs one instruction from FETCH to instr_done. Acts as a memory that
  // holds mem_ready low for a chosen number of cycles per access.
  task automatic run_instr(input logic [5:0] op, fn, input logic z,
                           input int unsigned l0, l1, output stats_t s);
    bit active, done;
    int unsigned wl, acc;
    logic mr;
    s = '{default: 0};
    s.ctl = 15;
    active = 0; done = 0; wl = 0; acc = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin bus.opcode = op; bus.funct = fn; bus.zero = z; end
      if (bus.mem_read || bus.mem_write) begin
        if (!active) begin active = 1; wl = (acc == 0) ? l0 : l1; acc++; end
        mr = (wl == 0);
        if (wl != 0) wl--;
        if (mr) active = 0;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      bus.mem_ready = mr;
      #1;
      trace[c] = outs();
      s.cycles++;
      s.rd   += bus.mem_read;
      s.wr   += bus.mem_write;
      s.both += (bus.mem_read & bus.mem_write);
      if (bus.reg_write) begin
        s.rw++;
        s.rw_rd += bus.reg_dst;
        s.m2r   += bus.mem_to_reg;
      end
      s.irw += bus.ir_write;
      s.pcw += bus.pc_write;
      if (bus.pc_write_cond) begin s.pcc++; s.bne = bus.branch_ne; end
      s.ill += bus.illegal;
      if (bus.alu_src_a) s.ctl = bus.alu_ctl;
      if (bus.instr_done) done = 1;
    end
    if (!done) s.cycles = 999;
  endtask

  task automatic step(input logic mr);
    @(posedge clk); #1;
    bus.mem_ready = mr;
    #1;
  endtask

  task automatic cmp_all(input string tag, input stats_t a, input stats_t e);
    chk({tag, ".cycles"}, a.cycles, e.cycles);
    chk({tag, ".mem_read"}, a.rd, e.rd);
    chk({tag, ".mem_write"}, a.wr, e.wr);
    chk({tag, ".reg_write"}, a.rw, e.rw);
    chk({tag, ".reg_dst"}, a.rw_rd, e.rw_rd);
    chk({tag, ".mem_to_reg"}, a.m2r, e.m2r);
    chk({tag, ".ir_write"}, a.irw, e.irw);
    chk({tag, ".pc_write"}, a.pcw, e.pcw);
    chk({tag, ".pc_write_cond"}, a.pcc, e.pcc);
    chk({tag, ".branch_ne"}, a.bne, e.bne);
    chk({tag, ".illegal"}, a.ill, e.ill);
    chk({tag, ".both_strobes"}, a.both, 0);
    chk({tag, ".alu_ctl"}, a.ctl, e.ctl);
  endtask

  vec_t tbl [14];
  logic [5:0] ops [9];
  logic [5:0] fns [6];

  initial begin
    stats_t s, e;
    int unsigned hold;
    logic [5:0] op, fn;
    int unsigned l0, l1;

    tbl[0]  = '{6'h02, 6'h00, 1'b0, 3, 0, 0, 0, 0, 15};
    tbl[1]  = '{6'h2B, 6'h00, 1'b0, 4, 0, 0, 0, 0, 2};
    tbl[2]  = '{6'h08, 6'h00, 1'b0, 4, 1, 0, 0, 0, 2};
    tbl[3]  = '{6'h00, 6'h2A, 1'b0, 4, 1, 0, 0, 0, 7};
    tbl[4]  = '{6'h04, 6'h00, 1'b1, 3, 0, 1, 0, 0, 6};
    tbl[5]  = '{6'h04, 6'h00, 1'b0, 3, 0, 1, 0, 0, 6};
    tbl[6]  = '{6'h05, 6'h00, 1'b1, 3, 0, 1, 1, 0, 6};
    tbl[7]  = '{6'h05, 6'h00, 1'b0, 3, 0, 1, 1, 0, 6};
    tbl[8]  = '{6'h3F, 6'h20, 1'b0, 2, 0, 0, 0, 1, 15};
    tbl[9]  = '{6'h00, 6'h21, 1'b0, 2, 0, 0, 0, 1, 15};
    tbl[10] = '{6'h00, 6'h22, 1'b0, 4, 1, 0, 0, 0, 6};
    tbl[11] = '{6'h00, 6'h24, 1'b0, 4, 1, 0, 0, 0, 0};
    tbl[12] = '{6'h00, 6'h25, 1'b0, 4, 1, 0, 0, 0, 1};
    tbl[13] = '{6'h23, 6'h00, 1'b0, 5, 1, 0, 0, 0, 2};
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};

    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_zero", outs(), 0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("fetch_after_reset", outs(), w(0,0,0,0,1,0,0,0,0,0,0,2'd1,4'b0010,2'd0,0,0));

    // R-type add, cycle by cycle
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, s);
    chk("radd.cycles", s.cycles, 4);
    chk("radd.c1_fetch",  trace[0], w(1,0,0,0,1,0,1,0,0,0,0,2'd1,4'b0010,2'd0,0,0));
    chk("radd.c2_decode", trace[1], w(0,0,0,0,0,0,0,0,0,0,0,2'd3,4'b0010,2'd0,0,0));
    chk("radd.c3_exec",   trace[2], w(0,0,0,0,0,0,0,0,0,0,1,2'd0,4'b0010,2'd0,0,0));
    chk("radd.c4_wb",     trace[3], w(0,0,0,0,0,0,0,1,1,0,0,2'd0,4'b0000,2'd0,1,0));

    // LW with three wait cycles in MEM_READ
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, s);
    chk("lw_wait.cycles", s.cycles, 8);
    hold = 0;
    for (int i = 3; i < 7; i++) hold += (trace[i][17] & trace[i][16]);
    chk("lw_wait.mem_read_held", hold, 4);
    chk("lw_wait.mem_to_reg", s.m2r, 1);
    chk("lw_wait.wb_done", trace[7][1], 1);

    // Table with mem_ready effectively tied high
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, 0, 0, s);
      chk($sformatf("tbl%0d.cycles", i), s.cycles, tbl[i].cyc);
      chk($sformatf("tbl%0d.reg_write", i), s.rw, tbl[i].rw);
      chk($sformatf("tbl%0d.pc_write_cond", i), s.pcc, tbl[i].pcc);
      chk($sformatf("tbl%0d.branch_ne", i), s.bne, tbl[i].bne);
      chk($sformatf("tbl%0d.illegal", i), s.ill, tbl[i].ill);
      chk($sformatf("tbl%0d.alu_ctl", i), s.ctl, tbl[i].ctl);
    end

    // Reset during a MEM_WRITE wait
    step(1'b1);
    bus.opcode = 6'h2B; bus.funct = 6'h00;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("rst_mw.mem_write_before", bus.mem_write, 1);
    reset = 1'b1;
    #1;
    chk("rst_mw.mem_write_dropped", bus.mem_write, 0);
    chk("rst_mw.outputs_zero", outs(), 0);
    step(1'b0);
    chk("rst_mw.no_done", bus.instr_done, 0);
    reset = 1'b0;
    #1;
    chk("rst_mw.fetch_next", outs(), w(0,0,0,0,1,0,0,0,0,0,0,2'd1,4'b0010,2'd0,0,0));

    // Randomized instructions and memory latencies against the model
    for (int n = 0; n < 150; n++) begin
      int unsigned k;
      k  = $urandom_range(0, 9);
      op = (k == 9) ? 6'($urandom_range(0, 63)) : ops[k];
      k  = $urandom_range(0, 6);
      fn = (k == 6) ? 6'($urandom_range(0, 63)) : fns[k];
      l0 = $urandom_range(0, 3);
      l1 = $urandom_range(0, 3);
      run_instr(op, fn, 1'($urandom_range(0, 1)), l0, l1, s);
      e = model(op, fn, l0, l1);
      cmp_all($sformatf("rnd%0d_op%02h_fn%02h", n, op, fn), s, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
